// File: rtl/excesso3_desserializador.sv
// Serial excess-3 deserializer: frames LSB-first nibbles, decodes to BCD, buffers in a FIFO.
// Optional X3_ERR_CHECK_EN: reject invalid codes and raise the sticky erro flag.
module excesso3_desserializador #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Bin,
  input  logic       Ben,
  input  logic       rd,
  input  logic       clr_flags,
  output logic [3:0] dout,
  output logic       dvalid,
  output logic       cheio,
  output logic       erro,
  output logic       perdido
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  function automatic logic x3_valid(input logic [3:0] c);
    return (c >= 4'd3) && (c <= 4'd12);
  endfunction

  logic [1:0]    cnt_q;
  logic [2:0]    sr_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_f_q, cnt_f_d;
  logic          perdido_q, perdido_d;
  logic          erro_d;
  logic [3:0]    mem_q [FIFO_DEPTH];

  logic       done_s, valid_s, push_req_s, push_s, pop_s, drop_s;
  logic [3:0] code_s, bcd_s;

  // Frame completion, decode and FIFO handshake decisions
  always_comb begin
    done_s  = Ben && (cnt_q == 2'd3);
    code_s  = {Bin, sr_q};
    bcd_s   = code_s - 4'd3;
    valid_s = x3_valid(code_s);
`ifdef X3_ERR_CHECK_EN
    push_req_s = done_s && valid_s;
`else
    push_req_s = done_s;
`endif
    pop_s   = rd && dvalid;
    // A pop on the same edge frees the slot the push needs
    push_s  = push_req_s && (!cheio || pop_s);
    drop_s  = push_req_s && cheio && !pop_s;
    cnt_f_d = cnt_f_q;
    if (push_s && !pop_s) begin
      cnt_f_d = cnt_f_q + {{AW{1'b0}}, 1'b1};
    end else if (pop_s && !push_s) begin
      cnt_f_d = cnt_f_q - {{AW{1'b0}}, 1'b1};
    end else begin
      cnt_f_d = cnt_f_q;
    end
    if (drop_s) begin
      perdido_d = 1'b1;
    end else if (clr_flags) begin
      perdido_d = 1'b0;
    end else begin
      perdido_d = perdido_q;
    end
`ifdef X3_ERR_CHECK_EN
    if (done_s && !valid_s) begin
      erro_d = 1'b1;
    end else if (clr_flags) begin
      erro_d = 1'b0;
    end else begin
      erro_d = erro;
    end
`else
    erro_d = 1'b0;
`endif
  end

  // Bit framing, pointers, occupancy and sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= 2'd0;
      sr_q      <= 3'd0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_f_q   <= '0;
      perdido_q <= 1'b0;
      erro      <= 1'b0;
    end else begin
      if (Ben) begin
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q != 2'd3) begin
          sr_q[cnt_q] <= Bin;
        end
      end
      if (push_s) begin
        wptr_q <= wptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rptr_q <= rptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      cnt_f_q   <= cnt_f_d;
      perdido_q <= perdido_d;
      erro      <= erro_d;
    end
  end

  // Digit storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= bcd_s;
    end
  end

  // Status decode and gated head read
  always_comb begin
    dvalid  = (cnt_f_q != '0);
    cheio   = (cnt_f_q == DEPTH_C);
    perdido = perdido_q;
    if (dvalid) begin
      dout = mem_q[rptr_q];
    end else begin
      dout = 4'd0;
    end
  end

endmodule

// File: doc/excesso3_desserializador.md
# excesso3_desserializador

- Downstream stage of the serial BCD→excess-3 converter.
- Consumes the converter's serial excess-3 bit stream (LSB first, 4 bits per digit) and frames it into nibbles.
- Decodes each nibble back to BCD, checks code validity and buffers decoded digits in a small FIFO for a parallel consumer with a pop handshake.

## Interface
- `FIFO_DEPTH`, default 4: number of digit entries; power of two, ≥2.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `Bin`  in  1: serial excess-3 bit, LSB of each digit first.
- `Ben`  in  1: bit qualifier; `Bin` is sampled only on edges where `Ben`=1.
- `rd`  in  1: pop request for the FIFO head.
- `clr_flags`  in  1: synchronous clear of the sticky flags.
- `dout`  out  4: BCD digit at the FIFO head; 0 when empty.
- `dvalid`  out  1: FIFO not empty.
- `cheio`  out  1: FIFO full.
- `erro`  out  1: sticky; an invalid excess-3 code was received.
- `perdido`  out  1: sticky; a digit was dropped because the FIFO was full.

## Operation
- **Bit counter** `cnt` (2 bits) counts 0..3 and advances only when `Ben`=1.
  - Each qualified bit is stored as `sr[cnt] <= Bin`.
  - On the qualified bit with `cnt`=3, `code = {Bin, sr[2:0]}` completes; `cnt` wraps to 0.
- **Decode:** `bcd = code - 4'd3`, truncated to 4 bits (mod 16).
  - Valid codes are 3..12 inclusive; all others are invalid.
- **Push:** on digit completion, write `bcd` at `wptr` if the code is valid (see Configuration).
- **Pop:** `rd`=1 with `dvalid`=1 advances `rptr`. `rd` is ignored when empty.
- **Pointers:** `rptr`, `wptr` are log2(FIFO_DEPTH) bits and wrap naturally.
  - Occupancy `cnt_f` is log2(FIFO_DEPTH)+1 bits.
  - `cheio` = (`cnt_f` == FIFO_DEPTH); `dvalid` = (`cnt_f` != 0).
- **Full FIFO:**
  - Push with `rd`=1 in the same cycle: both occur and occupancy is unchanged.
  - Push with `rd`=0: the digit is dropped and `perdido` is set.
- **Empty FIFO:** push and `rd` in the same cycle pushes only. No fall-through pop; the pushed digit is read on a later cycle.
- **Sticky flags:** `erro` and `perdido` are cleared by `clr_flags`. If set and clear occur in the same cycle, set wins.
- **`dout`:** combinational read of `mem[rptr]`, gated to 0 when empty.
- **Reset** (asynchronous, any time including mid-digit):
  - `cnt`=0, `sr`=0, pointers and occupancy 0.
  - Any partial digit is discarded.
  - Output reset values: `dout`=0, `dvalid`=0, `cheio`=0, `erro`=0, `perdido`=0. FIFO memory is not reset.

## Timing
- Latency: the edge that samples the 4th qualified bit writes the FIFO. `dvalid`/`dout` reflect the new digit immediately after that edge (0 cycles beyond the last bit).
- Throughput: 1 digit per 4 qualified bits. `Ben` may drop for any number of cycles between bits; `cnt` and `sr` hold.
- Pop: `dout` shows the next entry after the edge on which `rd`=1 was sampled.
- `erro` and `perdido` rise on the same edge as the offending completion.
- `cheio` rises on the edge of the push that fills the FIFO and falls on the edge of the first pop.
- Release of `reset` is not synchronized internally; the upstream driver holds `Ben`=0 for at least one cycle after release.

## Configuration
- `X3_ERR_CHECK_EN` defined:
  - Invalid codes (0,1,2,13,14,15) set `erro` and are not pushed.
- `X3_ERR_CHECK_EN` undefined:
  - Every completed code is pushed as `code-3` mod 16; invalid codes still generate a push.
  - `erro` is tied to 0; `clr_flags` affects only `perdido`.

## Test plan
- Reset, then `Bin` = 0,0,0,1 with `Ben`=1 (code 1000) → after 4th edge `dvalid`=1, `dout`=5; `rd` one cycle → `dvalid`=0, `dout`=0.
- Bits 0,0,0,1 with `Ben`=0 gaps of 3 cycles between bits → same result, `dout`=5. `cnt` must not advance during gaps.
- Bits 1,1,1,1 (code 1111):
  - Macro on → `erro`=1, `dvalid` stays 0; `clr_flags` → `erro`=0.
  - Macro off → `dout`=4'hC, `erro`=0.
- FIFO_DEPTH=4, digits 3,4,5,6,7 without `rd` (codes 0110,0111,1000,1001,1010) → `cheio`=1 after 4th digit, `perdido`=1 after 5th; pops return 3,4,5,6, then `dvalid`=0.
- Full FIFO with `rd`=1 on the completing edge of a new digit 9 (code 1100) → `perdido`=0, `cheio` stays 1, head advances, last entry = 9.
- Two bits sent, `reset` pulsed low mid-cycle, then bits 0,1,1,0 (code 0110) → exactly one digit, `dout`=3; all outputs 0 during reset.
